// File: rtl/div_pkg.sv
// div_pkg: shared width, operation and state types for the iterative divider.
package div_pkg;
    localparam int DIV_XLEN = 32;
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } div_state_e;
endpackage

// File: rtl/div_if.sv
// div_if: request/result bundle between the issuing pipeline and div_unit.
interface div_if import div_pkg::*; #(parameter int XLEN = DIV_XLEN);
    logic            i_start;
    div_op_e         i_op;
    logic [XLEN-1:0] i_rs1_data;
    logic [XLEN-1:0] i_rs2_data;
    logic [4:0]      i_rd_addr;
    logic            o_busy;
    logic            o_done;
    logic            o_rd_wren;
    logic [4:0]      o_rd_addr;
    logic [XLEN-1:0] o_rd_data;
    modport master (output i_start, i_op, i_rs1_data, i_rs2_data, i_rd_addr,
                    input  o_busy, o_done, o_rd_wren, o_rd_addr, o_rd_data);
    modport slave  (input  i_start, i_op, i_rs1_data, i_rs2_data, i_rd_addr,
                    output o_busy, o_done, o_rd_wren, o_rd_addr, o_rd_data);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring radix-2 step on unsigned magnitudes.
module div_step import div_pkg::*; #(parameter int XLEN = DIV_XLEN) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);
    logic [XLEN:0] sh;
    logic [XLEN:0] diff;
    assign sh    = {rem_i, bit_i};
    assign diff  = sh - {1'b0, dvs_i};
    // A borrow out of the top bit means the divisor did not fit: restore.
    assign q_o   = ~diff[XLEN];
    assign rem_o = q_o ? diff[XLEN-1:0] : sh[XLEN-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: 32-step iterative signed/unsigned divider with remainder.
module div_unit import div_pkg::*; #(parameter int XLEN = DIV_XLEN) (
    input  logic i_clk,
    input  logic i_rst,
    div_if.slave bus
);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    div_state_e      state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic            is_rem_q, is_rem_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic            busy_q, busy_d, done_q, done_d, wren_q, wren_d;
    logic            sgn, a_neg, b_neg, div0, ovf, step_q;
    logic [XLEN-1:0] abs_a, abs_b, step_rem, quo_next;

    assign sgn      = ~bus.i_op[0];
    assign a_neg    = sgn & bus.i_rs1_data[XLEN-1];
    assign b_neg    = sgn & bus.i_rs2_data[XLEN-1];
    assign abs_a    = a_neg ? -bus.i_rs1_data : bus.i_rs1_data;
    assign abs_b    = b_neg ? -bus.i_rs2_data : bus.i_rs2_data;
    assign div0     = bus.i_rs2_data == '0;
    assign ovf      = sgn & (bus.i_rs1_data == MIN_NEG) & (bus.i_rs2_data == '1);
    assign quo_next = {quo_q[XLEN-2:0], step_q};

    // The quotient register doubles as the dividend shifter: its MSB feeds each step.
    div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .bit_i (quo_q[XLEN-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        is_rem_d  = is_rem_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.i_start) begin
                rd_addr_d = bus.i_rd_addr;
                is_rem_d  = bus.i_op[1];
                qneg_d    = a_neg ^ b_neg;
                rneg_d    = a_neg;
                rem_d     = '0;
                quo_d     = abs_a;
                dvs_d     = abs_b;
                cnt_d     = '0;
                state_d   = (div0 || ovf) ? S_DONE : S_CALC;
                done_d    = div0 || ovf;
                rd_data_d = div0 ? (bus.i_op[1] ? bus.i_rs1_data : '1)
                                 : (bus.i_op[1] ? '0 : MIN_NEG);
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = quo_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    rd_data_d = is_rem_q ? (rneg_q ? -step_rem : step_rem)
                                         : (qneg_q ? -quo_next : quo_next);
                end
            end
            default: state_d = S_IDLE;
        endcase
        wren_d = done_d & (rd_addr_d != 5'd0);
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            is_rem_q  <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wren_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            is_rem_q  <= is_rem_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wren_q    <= wren_d;
        end
    end

    assign bus.o_busy    = busy_q;
    assign bus.o_done    = done_q;
    assign bus.o_rd_wren = wren_q;
    assign bus.o_rd_addr = rd_addr_q;
    assign bus.o_rd_data = rd_data_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized scoreboard bench for div_unit against an arithmetic reference.
module tb_div_unit;
    import div_pkg::*;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic        wren;
        int          due;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    exp_t me;

    div_if #(.XLEN(32)) bus();
    div_unit #(.XLEN(32)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (op == 2'b00) return (a == MIN_NEG && b == 32'hFFFF_FFFF) ? MIN_NEG : 32'(sa / sb);
        if (op == 2'b10) return (a == MIN_NEG && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
        if (op == 2'b01) return a / b;
        return a % b;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return b == 0 || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF);
    endfunction

    always @(negedge i_clk) begin
        if (bus.o_done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done cyc=%0d act=1 exp=0", cyc);
            end else begin
                me = sbq.pop_front();
                chk("rd_data", bus.o_rd_data, me.data);
                chk("rd_addr", 32'(bus.o_rd_addr), 32'(me.addr));
                chk("rd_wren", 32'(bus.o_rd_wren), 32'(me.wren));
                chk("latency", cyc, me.due);
            end
        end else if (bus.o_rd_wren) begin
            chk("wren_without_done", 32'(bus.o_rd_wren), 32'h0);
        end
    end

    // mode 0: plain, 1: extra start at +5, 2: reset at +10
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int mode);
        int c;
        int k;
        exp_t e;
        @(posedge i_clk); #1;
        bus.i_start = 1'b1;
        bus.i_op = div_op_e'(op);
        bus.i_rs1_data = a;
        bus.i_rs2_data = b;
        bus.i_rd_addr = rd;
        c = cyc;
        e.data = ref_div(op, a, b);
        e.addr = rd;
        e.wren = rd != 0;
        e.due = c + (is_special(op, a, b) ? 1 : 33);
        sbq.push_back(e);
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        bus.i_rs1_data = $urandom;
        bus.i_rs2_data = $urandom | 32'h1;
        bus.i_rd_addr = 5'($urandom);
        if (mode == 2) begin
            while (cyc < c + 10) begin @(posedge i_clk); #1; end
            i_rst = 1'b1;
            sbq.delete();
            @(posedge i_clk); #1;
            i_rst = 1'b0;
            chk("busy_after_abort", 32'(bus.o_busy), 32'h0);
            chk("data_after_abort", bus.o_rd_data, 32'h0);
            while (cyc < c + 40) begin @(posedge i_clk); #1; end
            chk("busy_idle_after_abort", 32'(bus.o_busy), 32'h0);
        end else begin
            k = 0;
            while (!bus.o_done && k < 40) begin
                bus.i_start = (mode == 1) && (cyc == c + 5);
                @(posedge i_clk); #1;
                k++;
            end
            bus.i_start = 1'b0;
            if (!bus.o_done) begin
                total++;
                bad++;
                $display("FAIL done_timeout cyc=%0d act=0 exp=1", cyc);
            end
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        int          sel;
        bus.i_start = 1'b0;
        bus.i_op = OP_DIV;
        bus.i_rs1_data = '0;
        bus.i_rs2_data = '0;
        bus.i_rd_addr = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_busy", 32'(bus.o_busy), 32'h0);
        chk("rst_done", 32'(bus.o_done), 32'h0);
        chk("rst_wren", 32'(bus.o_rd_wren), 32'h0);
        chk("rst_addr", 32'(bus.o_rd_addr), 32'h0);
        chk("rst_data", bus.o_rd_data, 32'h0);
        i_rst = 1'b0;

        issue(2'b01, 32'd100, 32'd7, 5'd3, 0);
        issue(2'b11, 32'd100, 32'd7, 5'd4, 0);
        issue(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        issue(2'b01, 32'd5, 32'd0, 5'd7, 0);
        issue(2'b10, 32'd5, 32'd0, 5'd8, 0);
        issue(2'b00, MIN_NEG, 32'hFFFF_FFFF, 5'd9, 0);
        issue(2'b10, MIN_NEG, 32'hFFFF_FFFF, 5'd10, 0);
        issue(2'b01, MIN_NEG, 32'hFFFF_FFFF, 5'd11, 0);
        issue(2'b00, 32'd100, 32'hFFFF_FFF9, 5'd0, 0);
        issue(2'b01, 32'd1000, 32'd9, 5'd12, 1);
        issue(2'b11, 32'hDEAD_BEEF, 32'd1234, 5'd13, 2);

        @(posedge i_clk); #1;
        i_rst = 1'b1;
        bus.i_start = 1'b1;
        bus.i_op = OP_DIVU;
        bus.i_rs1_data = 32'd100;
        bus.i_rs2_data = 32'd7;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        bus.i_start = 1'b0;
        chk("rst_start_busy", 32'(bus.o_busy), 32'h0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_start_busy_later", 32'(bus.o_busy), 32'h0);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            sel = int'($urandom_range(0, 9));
            a = $urandom;
            b = (sel == 0) ? 32'h0 : (sel < 4) ? 32'($urandom_range(1, 300)) : $urandom;
            if (sel == 1 && $urandom_range(0, 1) == 1) b = -b;
            if (sel == 9) begin
                a = MIN_NEG;
                b = 32'hFFFF_FFFF;
            end
            issue(op, a, b, 5'($urandom), (i % 7 == 3) ? 1 : 0);
        end

        repeat (40) @(posedge i_clk);
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d act=running exp=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: XLEN, 32, operand and result width; only 32 SHALL be verified.
REQ-002 i_clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_start  input  1  request to begin a division; accepted only in IDLE.
REQ-005 i_op  input  2  operation, div_op_e: DIV=00, DIVU=01, REM=10, REMU=11.
REQ-006 i_rs1_data  input  XLEN  dividend, taken from the register-file rs1 read port.
REQ-007 i_rs2_data  input  XLEN  divisor, taken from the register-file rs2 read port.
REQ-008 i_rd_addr  input  5  destination register tag, carried through to the result.
REQ-009 o_busy  output  1  high whenever state != IDLE.
REQ-010 o_done  output  1  one-cycle result-valid pulse.
REQ-011 o_rd_wren  output  1  register-file write enable; equals o_done, except it SHALL be 0 when the captured rd address is 0.
REQ-012 o_rd_addr  output  5  captured rd tag, valid while o_done=1.
REQ-013 o_rd_data  output  XLEN  quotient or remainder, valid while o_done=1.

Function
REQ-014 States SHALL be IDLE, CALC and DONE.
REQ-015 In IDLE with i_start=1 at cycle N, the block SHALL latch i_op, both operands and i_rd_addr.
- Normal case: next state CALC at N+1.
- Special cases (REQ-018, REQ-019): next state DONE at N+1.
REQ-016 CALC SHALL perform exactly 32 restoring radix-2 steps on unsigned magnitudes, one step per cycle (cycles N+1..N+32), then enter DONE at N+33.
REQ-017 Signed ops (DIV, REM) SHALL divide absolute values.
- Quotient is negated when operand signs differ.
- Remainder takes the sign of the dividend.
- Sign fix-up occurs on the CALC->DONE transition.
REQ-018 Divisor 0: quotient SHALL be 0xFFFFFFFF and remainder SHALL equal the dividend, for signed and unsigned ops alike.
REQ-019 DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient SHALL be 0x80000000 and remainder 0.
REQ-020 In DONE, o_done=1 for exactly one cycle and o_rd_data/o_rd_addr SHALL be registered values; the next state is IDLE unconditionally.
REQ-021 i_start SHALL be ignored in CALC and DONE: no relatch, no queueing, no effect on the result in flight.
REQ-022 Operand inputs may change after acceptance without affecting the result.
REQ-023 Latency from i_start to o_done SHALL be 33 cycles for normal ops and 1 cycle for special cases.
REQ-024 Back-to-back throughput: the earliest next acceptance is the cycle after DONE (the IDLE cycle).

Reset
REQ-025 While i_rst=1 at a clock edge, the block SHALL enter IDLE and clear o_busy, o_done, o_rd_wren, o_rd_addr and o_rd_data to 0.
REQ-026 Reset asserted mid-CALC or in DONE SHALL abort the operation; no o_done pulse for it may appear afterwards.
REQ-027 If i_rst and i_start are asserted in the same cycle, reset wins and the request is dropped.

Structure
REQ-028 Package div_pkg SHALL hold div_op_e, the state enum div_state_e and the XLEN default constant.
REQ-029 One combinational sub-module, div_step, SHALL implement a single restoring step (partial remainder, divisor -> next partial remainder, quotient bit); div_unit instantiates it once and iterates it.

Verification
REQ-030 DIVU 100/7, start at cycle N -> o_done at N+33, o_rd_data=14; REMU same operands -> 2.
REQ-031 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); o_done at N+33.
REQ-032 DIVU 5/0 -> o_done at N+1, data 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+1; REM same operands -> 0.
REQ-033 Reset mid-operation: i_rst=1 at N+10 of a normal op -> o_busy=0 from N+11, no o_done through N+40.
REQ-034 Start while busy: second i_start at N+5 with different operands -> single o_done at N+33 carrying the first result.
- rd_addr=0 -> o_done=1 with o_rd_wren=0.
